imem_fetch: RTL
===============

# imem_fetch

Parametrised, handshaked instruction memory that replaces the fixed combinational program ROM in front of the RISC-V core. It holds 2^ADDR_BITS 32-bit words that reset to the default boot image. It serves fetches through a registered valid/ready request/response pair with one-cycle latency. An optional byte-serial loader rewrites the program through the few spare TinyTapeout pins.

## Interface
- ADDR_BITS, 4: log2 of depth in 32-bit words (depth = 2^ADDR_BITS, minimum 2).
- NOP_WORD, 32'h00000013: value of unused image words and of error responses' data field.
- clk  in  1  single clock; all state on rising edge.
- rst  in  1  reset, synchronous, active-high.
- req_valid  in  1  fetch request present.
- req_addr  in  32  byte address (PC).
- req_ready  out  1  request accepted when req_valid && req_ready.
- rsp_valid  out  1  response present.
- rsp_data  out  32  instruction word, little-endian.
- rsp_err  out  1  misaligned request (req_addr[1:0] != 0).
- rsp_ready  in  1  consumer takes response when rsp_valid && rsp_ready.
- prog_en  in  1  loader session active (level).
- prog_byte_valid  in  1  prog_byte strobe.
- prog_byte  in  8  program byte, least-significant byte of each word first.
- prog_busy  out  1  loader in LOAD state.
- prog_words  out  ADDR_BITS+1  words written in the current/last session, saturating at 2^ADDR_BITS.

## Operation
- Reset image: word0=0x00100093, word1=0x00108093, word2=0x00010113, word3=0xFFE1F0E3, all others NOP_WORD. Every synchronous reset reloads this image, including after a program load.
- Word index = req_addr[ADDR_BITS+1:2]. Upper bits are ignored, so addresses wrap modulo depth.
- Fetch path: one response register.
  - req_ready = !rst && !prog_en && (!rsp_valid || rsp_ready).
  - On accept: rsp_data = mem[index], rsp_err = 0. If misaligned: rsp_data = NOP_WORD, rsp_err = 1.
  - rsp_valid set on accept. It clears on consume with no new accept.
  - rsp_data/rsp_err stay stable while rsp_valid && !rsp_ready.
- Loader FSM, states IDLE and LOAD.
  - IDLE→LOAD on prog_en=1. Entry clears the byte counter, word pointer and prog_words.
  - In LOAD, each prog_byte_valid shifts prog_byte into byte lane [byte counter]. On the 4th byte the assembled word is written to mem[pointer] that same edge, then the pointer is incremented (wraps at depth) and prog_words is incremented (saturating).
  - LOAD→IDLE on prog_en=0. A partial word (1-3 bytes) is discarded and memory is unchanged. prog_words holds its value until the next session.
  - prog_busy = (state == LOAD).
- A response already held when prog_en rises stays valid and unchanged until consumed. It is not refreshed by new writes.

## Timing
- Reset values: req_ready=0 during rst, rsp_valid=0, rsp_data=0, rsp_err=0, prog_busy=0, prog_words=0, FSM=IDLE, memory=reset image.
- Fetch latency: 1 cycle (accept at edge N, rsp_valid high after edge N).
- Full throughput: one fetch per cycle while rsp_ready=1.
- Simultaneous accept and consume: new response replaces old at the same edge. No bubble.
- Fetch reads after a loader write: the first request accepted after prog_en falls sees all written words.
- prog_en rising and req_valid in the same cycle: req_ready=0, so the request is not accepted.
- rst mid-LOAD or mid-response: everything returns to reset values and the image is restored at that edge.

## Configuration
- IMEM_PROG_EN defined: loader FSM and writable array as above.
- IMEM_PROG_EN undefined: array is constant (reset image only). prog_* inputs are ignored. prog_busy=0 and prog_words=0 permanently. req_ready ignores prog_en. Port list is identical in both builds.

## Test plan
- After reset, stream addresses 0x0, 0x4, 0x8, 0xC with rsp_ready=1 → responses 0x00100093, 0x00108093, 0x00010113, 0xFFE1F0E3, one per cycle, 1-cycle latency.
- ADDR_BITS=4: req_addr=0x44 → 0x00108093 (wrap). req_addr=0x3C → 0x00000013.
- req_addr=0x2 → rsp_err=1, rsp_data=0x00000013. The next request to 0x0 → rsp_err=0.
- Hold rsp_ready=0 for 3 cycles after a response → req_ready=0 and rsp_data stable. Release → resumes with no loss or duplication.
- IMEM_PROG_EN: prog_en=1, bytes 13 05 10 00 93 → word0=0x00100513, prog_words=1. Drop prog_en → trailing 0x93 discarded and word1 still 0x00108093. Fetch 0x0 → 0x00100513.
- IMEM_PROG_EN: load 2 words, then assert rst → fetch 0x0 returns 0x00100093 and prog_words=0.

Source files
------------

// File: rtl/imem_fetch_if.sv
// ---------------------------------------------------------------------------
// imem_fetch_if : fetch request/response bus between the core and imem_fetch.
//   req_valid / req_addr / req_ready : fetch request (byte address = PC)
//   rsp_valid / rsp_data / rsp_err / rsp_ready : fetch response
// master = core side, slave = instruction memory side.
// ---------------------------------------------------------------------------
interface imem_fetch_if;
   logic        req_valid;
   logic [31:0] req_addr;
   logic        req_ready;
   logic        rsp_valid;
   logic [31:0] rsp_data;
   logic        rsp_err;
   logic        rsp_ready;

   modport master (
      output req_valid, req_addr, rsp_ready,
      input  req_ready, rsp_valid, rsp_data, rsp_err
   );

   modport slave (
      input  req_valid, req_addr, rsp_ready,
      output req_ready, rsp_valid, rsp_data, rsp_err
   );
endinterface

// File: rtl/imem_fetch.sv
// ---------------------------------------------------------------------------
// imem_fetch : handshaked instruction memory with one-cycle fetch latency,
// 2^ADDR_BITS 32-bit words reset to the boot image on every synchronous reset.
//
// Build option: define IMEM_PROG_EN to enable the byte-serial loader and a
// writable array; otherwise the array is the constant boot image and the
// prog_* inputs are ignored (prog_busy_o = 0, prog_words_o = 0).
//
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   bus (slave)       : req_valid/req_addr/req_ready, rsp_valid/rsp_data/
//                       rsp_err/rsp_ready fetch handshake
//   prog_en_i         : loader session active (level)
//   prog_byte_valid_i : prog_byte_i strobe
//   prog_byte_i       : program byte, LSB of each word first
//   prog_busy_o       : loader in LOAD state
//   prog_words_o      : words written this/last session, saturating at depth
// ---------------------------------------------------------------------------
module imem_fetch #(
   parameter int unsigned ADDR_BITS = 4,
   parameter logic [31:0] NOP_WORD  = 32'h0000_0013
) (
   input  logic                 clk,
   input  logic                 rst,
   imem_fetch_if.slave          bus,
   input  logic                 prog_en_i,
   input  logic                 prog_byte_valid_i,
   input  logic [7:0]           prog_byte_i,
   output logic                 prog_busy_o,
   output logic [ADDR_BITS:0]   prog_words_o
);

   // Boot image contents for word index idx.
   function automatic logic [31:0] boot_word(input int unsigned idx);
      case (idx)
         0:       boot_word = 32'h0010_0093;
         1:       boot_word = 32'h0010_8093;
         2:       boot_word = 32'h0001_0113;
         3:       boot_word = 32'hFFE1_F0E3;
         default: boot_word = NOP_WORD;
      endcase
   endfunction

   logic [ADDR_BITS-1:0] idx_c;
   logic                 misaligned_c;
   logic                 accept_c;
   logic                 prog_hold_c;
   logic [31:0]          rd_word_c;
   logic                 unused_addr_c;

   logic                 rsp_valid_q;
   logic [31:0]          rsp_data_q;
   logic                 rsp_err_q;

   // Upper address bits are ignored: addresses wrap modulo depth.
   assign idx_c         = bus.req_addr[ADDR_BITS+1:2];
   assign misaligned_c  = |bus.req_addr[1:0];
   assign unused_addr_c = ^bus.req_addr[31:ADDR_BITS+2];

   assign bus.req_ready = !rst && !prog_hold_c && (!rsp_valid_q || bus.rsp_ready);
   assign accept_c      = bus.req_valid && bus.req_ready;

   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_data  = rsp_data_q;
   assign bus.rsp_err   = rsp_err_q;

   // Single response register; an accept on a consume edge replaces it directly.
   always_ff @(posedge clk) begin
      if (rst) begin
         rsp_valid_q <= 1'b0;
         rsp_data_q  <= 32'h0;
         rsp_err_q   <= 1'b0;
      end else if (accept_c) begin
         rsp_valid_q <= 1'b1;
         rsp_data_q  <= misaligned_c ? NOP_WORD : rd_word_c;
         rsp_err_q   <= misaligned_c;
      end else if (bus.rsp_ready) begin
         rsp_valid_q <= 1'b0;
      end
   end

`ifdef IMEM_PROG_EN
   localparam int unsigned DEPTH = 1 << ADDR_BITS;

   localparam logic [0:0] S_IDLE = 1'b0;
   localparam logic [0:0] S_LOAD = 1'b1;

   logic [0:0]           state_q,    state_d;
   logic [1:0]           byte_cnt_q, byte_cnt_d;
   logic [ADDR_BITS-1:0] ptr_q,      ptr_d;
   logic [ADDR_BITS:0]   words_q,    words_d;
   logic [23:0]          asm_q,      asm_d;
   logic                 wr_en_c;
   logic [31:0]          wr_word_c;
   logic [31:0]          mem_q [DEPTH];

   assign prog_hold_c  = prog_en_i;
   assign rd_word_c    = mem_q[idx_c];
   assign prog_busy_o  = (state_q == S_LOAD);
   assign prog_words_o = words_q;

   // Loader next state: bytes 0..2 collect in asm, byte 3 completes the word.
   always_comb begin
      state_d    = state_q;
      byte_cnt_d = byte_cnt_q;
      ptr_d      = ptr_q;
      words_d    = words_q;
      asm_d      = asm_q;
      wr_en_c    = 1'b0;
      wr_word_c  = {prog_byte_i, asm_q};
      case (state_q)
         S_IDLE: begin
            if (prog_en_i) begin
               state_d    = S_LOAD;
               byte_cnt_d = 2'd0;
               ptr_d      = '0;
               words_d    = '0;
               asm_d      = 24'h0;
            end
         end
         S_LOAD: begin
            if (!prog_en_i) begin
               // Any partial word is simply dropped.
               state_d    = S_IDLE;
               byte_cnt_d = 2'd0;
            end else if (prog_byte_valid_i) begin
               byte_cnt_d = byte_cnt_q + 2'd1;
               case (byte_cnt_q)
                  2'd0: asm_d[7:0]   = prog_byte_i;
                  2'd1: asm_d[15:8]  = prog_byte_i;
                  2'd2: asm_d[23:16] = prog_byte_i;
                  default: begin
                     wr_en_c = 1'b1;
                     ptr_d   = ptr_q + ADDR_BITS'(1);
                     if (words_q != (ADDR_BITS+1)'(DEPTH))
                        words_d = words_q + (ADDR_BITS+1)'(1);
                  end
               endcase
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         byte_cnt_q <= 2'd0;
         ptr_q      <= '0;
         words_q    <= '0;
         asm_q      <= 24'h0;
      end else begin
         state_q    <= state_d;
         byte_cnt_q <= byte_cnt_d;
         ptr_q      <= ptr_d;
         words_q    <= words_d;
         asm_q      <= asm_d;
      end
   end

   // Writable array; reset restores the boot image.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int unsigned i = 0; i < DEPTH; i++)
            mem_q[i] <= boot_word(i);
      end else if (wr_en_c) begin
         mem_q[ptr_q] <= wr_word_c;
      end
   end
`else
   logic unused_prog_c;

   assign prog_hold_c   = 1'b0;
   assign rd_word_c     = boot_word(32'(idx_c));
   assign prog_busy_o   = 1'b0;
   assign prog_words_o  = '0;
   assign unused_prog_c = ^{prog_en_i, prog_byte_valid_i, prog_byte_i};
`endif

endmodule
